// File: rtl/nts_ip_parser.sv
`timescale 1ns/1ps
// Streaming Ethernet/IPv4/IPv6/UDP header parser for the NTS receive path.
// Classifies the frame, checks the IPv4 header sum and extracts UDP fields.
module nts_ip_parser #(
   parameter int          ADDR_WIDTH = 10,
   parameter logic [15:0] MATCH_PORT = 16'd123
) (
   input  logic        i_clk,
   input  logic        i_areset,
   input  logic        i_clear,
   input  logic        i_valid,
   input  logic        i_last,
   input  logic [7:0]  i_last_word_data_valid,
   input  logic [63:0] i_data,
   output logic        o_done,
   output logic        o_detect_ipv4,
   output logic        o_detect_ipv4_bad,
   output logic        o_detect_ipv6,
   output logic        o_detect_udp,
   output logic        o_ipv4_csum_ok,
   output logic        o_truncated,
   output logic        o_detect_port_match,
   output logic [15:0] o_udp_src_port,
   output logic [15:0] o_udp_dst_port,
   output logic [15:0] o_udp_length
);

   localparam int BW = ADDR_WIDTH + 4;

   typedef enum logic [1:0] {
      S_RX,
      S_FOLD,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [ADDR_WIDTH-1:0] r_wcnt;
   logic [BW-1:0]         r_bytes;
   logic [15:0]           r_etype;
   logic [3:0]            r_ver;
   logic [3:0]            r_ihl;
   logic [7:0]            r_proto;
   logic [20:0]           r_acc;
   logic [15:0]           r_src;
   logic [15:0]           r_dst;
   logic [15:0]           r_len;
   logic                  r_v4;
   logic                  r_v4bad;
   logic                  r_v6;
   logic                  r_udp;
   logic                  r_csum_ok;
   logic                  r_trunc;
   logic                  r_match;

   logic        w_accept;
   logic        w_sel1;
   logic        w_sel2;
   logic [15:0] w_etype;
   logic [3:0]  w_ver;
   logic [3:0]  w_ihl;
   logic        w_v4;
   logic        w_v4good;
   logic        w_v6;
   logic        w_ip;
   logic [5:0]  w_h;
   logic [5:0]  w_h_dst;
   logic [5:0]  w_h_len;
   logic [6:0]  w_uend;
   logic        w_hit_src;
   logic        w_hit_dst;
   logic        w_hit_len;
   logic [5:0]  w_half;
   logic [17:0] w_csum_add;
   logic [3:0]  w_pop;
   logic [16:0] w_a;
   logic [15:0] w_s;
   logic        w_trunc;

   function automatic logic [15:0] lane16(input logic [63:0] d,
                                          input logic [1:0]  l);
      logic [15:0] v;
      case (l)
         2'd0:    v = d[63:48];
         2'd1:    v = d[47:32];
         2'd2:    v = d[31:16];
         default: v = d[15:0];
      endcase
      return v;
   endfunction

   assign w_accept = (r_state == S_RX) && i_valid && !i_clear;
   assign w_sel1   = w_accept && (r_wcnt == ADDR_WIDTH'(1));
   assign w_sel2   = w_accept && (r_wcnt == ADDR_WIDTH'(2));

   // Word 1 decides the frame type for its own checksum lane.
   assign w_etype  = w_sel1 ? i_data[31:16] : r_etype;
   assign w_ver    = w_sel1 ? i_data[15:12] : r_ver;
   assign w_ihl    = w_sel1 ? i_data[11:8]  : r_ihl;

   assign w_v4     = (w_etype == 16'h0800) && (w_ver == 4'd4);
   assign w_v4good = w_v4 && (w_ihl >= 4'd5);
   assign w_v6     = (w_etype == 16'h86DD) && (w_ver == 4'd6);
   assign w_ip     = w_v4good || w_v6;

   // UDP header offset in 16-bit units: 7 + 2*ihl, or 27 for IPv6.
   assign w_h      = w_v6 ? 6'd27 : 6'd7 + {1'b0, w_ihl, 1'b0};
   assign w_h_dst  = w_h + 6'd1;
   assign w_h_len  = w_h + 6'd2;
   assign w_uend   = {w_h + 6'd4, 1'b0};

   assign w_hit_src = w_accept && w_ip &&
                      (r_wcnt == ADDR_WIDTH'(w_h[5:2]));
   assign w_hit_dst = w_accept && w_ip &&
                      (r_wcnt == ADDR_WIDTH'(w_h_dst[5:2]));
   assign w_hit_len = w_accept && w_ip &&
                      (r_wcnt == ADDR_WIDTH'(w_h_len[5:2]));

   always_comb begin
      w_csum_add = '0;
      w_half     = '0;
      for (int l = 0; l < 4; l++) begin
         w_half = {r_wcnt[3:0], 2'b00} + 6'(l);
         if (((r_wcnt >> 4) == '0) && (w_half >= 6'd7) &&
             (w_half < w_h))
            w_csum_add = w_csum_add + 18'(lane16(i_data, 2'(l)));
      end
   end

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < 8; i++)
         w_pop = w_pop + 4'(i_last_word_data_valid[i]);
   end

   assign w_a     = {1'b0, r_acc[15:0]} + {12'b0, r_acc[20:16]};
   assign w_s     = w_a[15:0] + {15'b0, w_a[16]};
   assign w_trunc = w_ip && (r_bytes < BW'(w_uend));

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_RX:    if (w_accept && i_last) w_next = S_FOLD;
         S_FOLD:  w_next = S_DONE;
         S_DONE:  w_next = S_DONE;
         default: w_next = S_RX;
      endcase
      if (i_clear)
         w_next = S_RX;
   end

   always_ff @(posedge i_clk or posedge i_areset) begin
      if (i_areset)
         r_state <= S_RX;
      else
         r_state <= w_next;
   end

   always_ff @(posedge i_clk or posedge i_areset) begin
      if (i_areset) begin
         r_wcnt    <= '0;
         r_bytes   <= '0;
         r_etype   <= '0;
         r_ver     <= '0;
         r_ihl     <= '0;
         r_proto   <= '0;
         r_acc     <= '0;
         r_src     <= '0;
         r_dst     <= '0;
         r_len     <= '0;
         r_v4      <= 1'b0;
         r_v4bad   <= 1'b0;
         r_v6      <= 1'b0;
         r_udp     <= 1'b0;
         r_csum_ok <= 1'b0;
         r_trunc   <= 1'b0;
         r_match   <= 1'b0;
      end else if (i_clear) begin
         r_wcnt    <= '0;
         r_bytes   <= '0;
         r_etype   <= '0;
         r_ver     <= '0;
         r_ihl     <= '0;
         r_proto   <= '0;
         r_acc     <= '0;
         r_src     <= '0;
         r_dst     <= '0;
         r_len     <= '0;
         r_v4      <= 1'b0;
         r_v4bad   <= 1'b0;
         r_v6      <= 1'b0;
         r_udp     <= 1'b0;
         r_csum_ok <= 1'b0;
         r_trunc   <= 1'b0;
         r_match   <= 1'b0;
      end else begin
         if (w_accept) begin
            if (r_wcnt != '1)
               r_wcnt <= r_wcnt + 1'b1;
            if (i_last)
               r_bytes <= BW'({r_wcnt, 3'b000}) + BW'(w_pop);
            if (w_v4good)
               r_acc <= r_acc + 21'(w_csum_add);
         end
         if (w_sel1) begin
            r_etype <= i_data[31:16];
            r_ver   <= i_data[15:12];
            r_ihl   <= i_data[11:8];
         end
         if (w_sel2 && w_v4good)
            r_proto <= i_data[7:0];
         else if (w_sel2 && w_v6)
            r_proto <= i_data[31:24];
         if (w_hit_src)
            r_src <= lane16(i_data, w_h[1:0]);
         if (w_hit_dst)
            r_dst <= lane16(i_data, w_h_dst[1:0]);
         if (w_hit_len)
            r_len <= lane16(i_data, w_h_len[1:0]);
         if (r_state == S_FOLD) begin
            r_v4      <= w_v4;
            r_v4bad   <= w_v4 && !w_v4good;
            r_v6      <= w_v6;
            r_udp     <= w_ip && (r_proto == 8'd17);
            r_trunc   <= w_trunc;
            r_csum_ok <= (w_s == 16'hFFFF) && w_v4good && !w_trunc;
            r_match   <= w_ip && (r_proto == 8'd17) &&
                         (r_dst == MATCH_PORT) && !w_trunc;
         end
      end
   end

   assign o_done              = (r_state == S_DONE);
   assign o_detect_ipv4       = r_v4;
   assign o_detect_ipv4_bad   = r_v4bad;
   assign o_detect_ipv6       = r_v6;
   assign o_detect_udp        = r_udp;
   assign o_ipv4_csum_ok      = r_csum_ok;
   assign o_truncated         = r_trunc;
   assign o_detect_port_match = r_match;
   assign o_udp_src_port      = r_src;
   assign o_udp_dst_port      = r_dst;
   assign o_udp_length        = r_len;

endmodule

// File: doc/nts_ip_parser.md
Name: nts_ip_parser

Overview:
- Streaming L2/L3/L4 header parser for the NTS engine receive path. It sits between the Ethernet receive buffer and the NTP/NTS processing blocks.
- Consumes 64-bit big-endian frame words. Classifies each frame as IPv4 or IPv6 and extracts the UDP ports and UDP length.
- IPv4 headers with options (IHL 5..15) are supported. The IPv4 header checksum is verified, frames too short for their headers are flagged, and frames addressed to a configurable UDP port are flagged.
- Results are held stable until the next frame starts.

Parameters:
- ADDR_WIDTH, 10, width of the saturating word counter (minimum 4).
- MATCH_PORT, 16'd123, UDP destination port that sets o_detect_port_match.

Ports:
- i_clk  in  1  clock.
- i_areset  in  1  reset: asynchronous, active-high; clears all state.
- i_clear  in  1  synchronous start-of-frame clear.
- i_valid  in  1  i_data holds the next frame word.
- i_last  in  1  qualifies the final word (ignored unless i_valid).
- i_last_word_data_valid  in  8  byte mask of the last word, MSB-first, contiguous (8'hFF = 8 bytes, 8'hC0 = 2 bytes).
- i_data  in  64  frame word; byte n of the frame is word n>>3, bits [63-8*(n%8) -: 8].
- o_done  out  1  results valid (level, held until clear).
- o_detect_ipv4  out  1  ethertype 0x0800 and version 4.
- o_detect_ipv4_bad  out  1  IPv4 with IHL < 5.
- o_detect_ipv6  out  1  ethertype 0x86DD and version 6.
- o_detect_udp  out  1  good IPv4 or IPv6 frame, protocol/next-header = 17.
- o_ipv4_csum_ok  out  1  IPv4 header one's-complement sum equals 16'hFFFF.
- o_truncated  out  1  frame ended before the UDP header end.
- o_detect_port_match  out  1  o_detect_udp && dst port == MATCH_PORT && !o_truncated.
- o_udp_src_port  out  16  UDP source port.
- o_udp_dst_port  out  16  UDP destination port.
- o_udp_length  out  16  UDP length field.

Behaviour:
- Reset (async) or i_clear (sync): all registers and outputs go to 0, and the FSM enters S_RX.
  - i_clear has priority over a same-cycle i_valid word; that word is dropped.
- Word counter w:
  - Starts at 0 and increments on each accepted word.
  - Saturates at 2^ADDR_WIDTH-1; no wrap.
  - Fields are taken only from words 0..9, so saturation has no effect on them.
- FSM has three states:
  - S_RX: accepts words. When i_valid && i_last, capture the byte count 8*w + popcount(mask) and go to S_FOLD.
  - S_FOLD: one cycle; folds the checksum and evaluates truncation. Go to S_DONE.
  - S_DONE: o_done=1. i_valid is ignored until i_clear.
  - Latency: o_done rises 2 cycles after the i_last word is accepted.
- Word 1 captures:
  - ethertype = [31:16]
  - version = [15:12]
  - ihl = [11:8]
- IPv4 fields:
  - protocol: byte 23, i.e. word 2 [7:0].
  - The UDP header starts at byte offset u = 14 + 4*ihl.
- IPv6 fields:
  - next header: byte 20, i.e. word 2 [31:24].
  - u = 54. No extension-header walking: next header != 17 means not UDP.
- 16-bit field at byte offset b: word b>>3, lane (b>>1)&3, bits [63-16*lane -: 16].
  - src = u, dst = u+2, length = u+4.
  - u%8 is 2 or 6. When it is 6, src comes from word u>>3 and dst/length come from the next word.
  - A field is captured only when its word arrives and only if the frame is a good IPv4 (ihl>=5) or IPv6 frame.
- IPv4 checksum:
  - Every lane whose byte offset lies in [14, 14+4*ihl) is added into a 21-bit accumulator.
  - In word 1, only lane 3 is in range; ihl comes from that same word.
  - Accumulation happens only while the frame is IPv4 with ihl>=5.
  - Fold in S_FOLD: a = acc[15:0] + acc[20:16]; s = a[15:0] + a[16].
  - o_ipv4_csum_ok = (s == 16'hFFFF) && IPv4 && !bad && !truncated.
- Truncation:
  - o_truncated = (IPv4 good || IPv6) && bytecount < u+8.
  - Ports and length remain whatever was captured.
- All detect flags are registered outputs. They are valid from S_DONE and may change earlier while words arrive; consumers sample on o_done.
- Non-IP frames: all detect flags 0, fields 0, o_done still asserted.
- Reset mid-frame: state is discarded immediately, with no partial o_done.

Test Plan:
- IPv4, IHL=5, 0800/4500, correct checksum, UDP src 0x1234 dst 0x007B len 0x0038, 11-word frame (last mask 8'hFF) -> o_done 2 cycles after last; ipv4=1, udp=1, csum_ok=1, port_match=1, ports/len exact.
- Same frame with checksum byte flipped -> csum_ok=0, udp=1, port_match=1.
- IPv4, IHL=7 (u=42, u%8=2) and IHL=6 (u=38, straddling) -> fields captured exactly (0x1234/0x007B/0x0038); IHL=3 -> ipv4_bad=1, udp=0, fields 0.
- IPv6 86DD/6, next header 17, dst 0x007B -> ipv6=1, udp=1, csum_ok=0, port_match=1; next header 6 -> udp=0.
- IPv4 UDP frame ending at word 4 with mask 8'hC0 (bytecount 34 < 42) -> truncated=1, port_match=0.
- i_clear asserted with i_valid mid-frame, then i_areset during S_FOLD -> all outputs 0, o_done never asserted; next frame parses correctly.
